ram_bist_ctrl: RTL and testbench
================================

Name: ram_bist_ctrl

Overview:
- Hardware initiator for the single-port RAM port (write_en, read_en, addr, data_in, data_out).
- Sits between a test-control register and the RAM, and runs a March C- test over every address.
- Reports pass/fail, the first failing address/data, and an error count.
- Drives the same signals the verification driver does, so the bench can substitute it for the driver.

Parameters:
- ADDR_W, 5, RAM address width; DEPTH = 2**ADDR_W.
- DATA_W, 8, RAM data width.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  pulse; starts a run when idle.
- busy  output  1  run in progress.
- done  output  1  one-cycle pulse at end of run.
- pass  output  1  last run had zero mismatches; valid from done until next start.
- err_cnt  output  8  mismatch count, saturates at 8'hFF.
- fail_addr  output  ADDR_W  address of first mismatch.
- fail_data  output  DATA_W  data_out value read at first mismatch.
- write_en  output  1  RAM write strobe.
- read_en  output  1  RAM read strobe.
- addr  output  ADDR_W  RAM address.
- data_in  output  DATA_W  RAM write data.
- data_out  input  DATA_W  RAM read data; valid the cycle after read_en (latency 1).

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0; FSM to IDLE; counters cleared.
- Reset asserted mid-run: abort immediately; no done pulse.
- Background patterns: B0 = all zeros, B1 = all ones.
- FSM states: IDLE, M0, M1, M2, M3, M4, M5, FLUSH, DONE.
- IDLE: busy=0. On start=1, clear err_cnt/fail_addr/fail_data and pass, then go to M0 next cycle. start is ignored in every other state.
- March elements:
  - M0, up: w B0, 1 cycle/addr.
  - M1, up: r B0 then w B1.
  - M2, up: r B1 then w B0.
  - M3, down: r B0 then w B1.
  - M4, down: r B1 then w B0.
  - M5, down: r B0, 1 cycle/addr.
- Read-write elements take 2 cycles per address: read cycle (read_en=1), then write cycle (write_en=1, same addr).
- write_en and read_en are never both high.
- Up elements start at 0 and end at DEPTH-1. Down elements start at DEPTH-1 and end at 0.
- On the terminal address, move to the next element on the following cycle with no idle gap.
- Compare pipeline: on each read, register the expected value and addr; compare against data_out on the next cycle.
- FLUSH: 1 cycle after the last M5 read, performs the final compare.
- DONE: busy=0, done=1 for 1 cycle, pass = (err_cnt==0); then IDLE.
- Timing for DEPTH=32: start sampled at edge N; busy=1 for 321 cycles (320 op + FLUSH); done=1 on the following cycle.
- On mismatch: err_cnt+1, saturating at 255. fail_addr/fail_data capture the first mismatch only and hold until the next start.
- Mismatch in the same cycle as the M5→FLUSH transition is still counted.
- addr and data_in are 0 whenever no strobe is active.

Optional Feature:
- Macro: RAM_BIST_STOP_ON_FAIL_EN.
- Defined: the first mismatch aborts the run. The next cycle goes to DONE: no further strobes, done pulses, pass=0, err_cnt=1.
- Undefined: the run always completes all elements, and err_cnt accumulates.

Decomposition:
- ram_bist_pkg:
  - state enum (IDLE..DONE);
  - march-element descriptor typedef (direction, read-expect background, write background, has_read, has_write);
  - constant array of the six descriptors;
  - ERR_CNT_W = 8.
- Sub-module ram_bist_addr_gen: up/down address counter with load (0 or DEPTH-1), step enable, and terminal flag.
- ram_bist_ctrl: FSM, compare pipeline, error capture.

Test Plan:
- Fault-free RAM model, start pulse → busy 321 cycles, done pulse, pass=1, err_cnt=0.
- Addr 5 bit 3 stuck-at-0 → mismatches in M2 and M4; err_cnt=2, fail_addr=5, fail_data=8'hF7, pass=0.
- Addr 31 stuck at 8'hA5 → first fail in M1 at addr 31 with fail_data=8'hA5; err_cnt=5; pass=0.
- start re-pulsed at cycle 50 of a run → ignored; done still arrives at cycle 322.
- rst low at cycle 100 → all outputs 0 asynchronously, no done. A new start afterwards runs the full 321 cycles with pass=1.
- With RAM_BIST_STOP_ON_FAIL_EN and the addr 5 fault → abort: done pulses 2 cycles after the M2 read of addr 5 (compare cycle, then DONE); err_cnt=1, fail_addr=5; no strobes after the compare cycle.

Source files
------------

// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: shared types and the March C- element table for ram_bist_ctrl.
package ram_bist_pkg;
  localparam int ERR_CNT_W = 8;
  typedef enum logic [3:0] {IDLE, M0, M1, M2, M3, M4, M5, FLUSH, DONE} state_e;
  typedef struct packed {
    logic down;
    logic rd_bg;
    logic wr_bg;
    logic has_rd;
    logic has_wr;
  } march_t;
  // M0..M5 in order, fields {down, rd_bg, wr_bg, has_rd, has_wr}
  localparam march_t [0:5] MARCH = {5'b00001, 5'b00111, 5'b01011, 5'b10111, 5'b11011, 5'b10010};
  function automatic march_t march_desc(state_e s);
    return (s >= M0 && s <= M5) ? MARCH[3'(s - M0)] : '0;
  endfunction
endpackage

// File: rtl/ram_bist_addr_gen.sv
// ram_bist_addr_gen: up/down address counter; a load picks the end (0 or DEPTH-1)
// and latches the direction used by later steps and the terminal flag.
module ram_bist_addr_gen #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              down,
  input  logic              step,
  output logic [ADDR_W-1:0] addr_nxt,
  output logic              last
);
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic dir_q, dir_d;
  always_comb begin
    dir_d  = load ? down : dir_q;
    addr_d = load ? (down ? '1 : '0)
           : step ? (dir_q ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1))
           : addr_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      dir_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      dir_q  <= dir_d;
    end
  end
  assign addr_nxt = addr_d;
  assign last     = dir_q ? (addr_q == '0) : (&addr_q);
endmodule

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: March C- BIST initiator for a single-port RAM with 1-cycle read latency.
// Define RAM_BIST_STOP_ON_FAIL_EN to abort the run at the first mismatch.
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [ADDR_W-1:0]    fail_addr,
  output logic [DATA_W-1:0]    fail_data,
  output logic                 write_en,
  output logic                 read_en,
  output logic [ADDR_W-1:0]    addr,
  output logic [DATA_W-1:0]    data_in,
  input  logic [DATA_W-1:0]    data_out
);
  state_e state_q, state_d;
  march_t nxt;
  logic wb_q, wb_d, ph_d, exp_q, exp_d, cmp_v_q, cmp_v_d, cmp_exp_q, cmp_exp_d;
  logic busy_q, busy_d, done_q, done_d, pass_q, pass_d, wr_q, wr_d, rd_q, rd_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d, addr_q, addr_d, cmp_addr_q, cmp_addr_d, ag_nxt;
  logic [DATA_W-1:0] fail_data_q, fail_data_d, din_q, din_d;
  logic ag_load, ag_step, ag_last, clr, mis, first, stop;

  ram_bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (ag_load),
    .down     (nxt.down),
    .step     (ag_step),
    .addr_nxt (ag_nxt),
    .last     (ag_last)
  );

  assign mis   = cmp_v_q && (data_out != {DATA_W{cmp_exp_q}});
  assign first = mis && (err_q == '0);
  assign clr   = (state_q == IDLE) && start;
`ifdef RAM_BIST_STOP_ON_FAIL_EN
  assign stop = mis;
`else
  assign stop = 1'b0;
`endif

  // wb_q marks that the read just issued is followed by a write to the same address
  always_comb begin
    state_d = state_q;
    ph_d    = 1'b0;
    ag_load = 1'b0;
    ag_step = 1'b0;
    if (state_q == IDLE) begin
      state_d = start ? M0 : IDLE;
      ag_load = start;
    end else if (stop || state_q == FLUSH) begin
      state_d = DONE;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else if (wb_q) begin
      ph_d = 1'b1;
    end else if (ag_last) begin
      state_d = state_e'(state_q + 4'd1);
      ag_load = 1'b1;
    end else begin
      ag_step = 1'b1;
    end
  end

  // Outputs are registered: decode the operation of the upcoming cycle
  always_comb begin
    nxt         = march_desc(state_d);
    rd_d        = nxt.has_rd && !ph_d;
    wr_d        = nxt.has_wr && (ph_d || !nxt.has_rd);
    wb_d        = rd_d && nxt.has_wr;
    exp_d       = nxt.rd_bg;
    addr_d      = (rd_d || wr_d) ? ag_nxt : '0;
    din_d       = wr_d ? {DATA_W{nxt.wr_bg}} : '0;
    busy_d      = (state_d != IDLE) && (state_d != DONE);
    done_d      = state_d == DONE;
    cmp_v_d     = rd_q && (state_d != DONE);
    cmp_exp_d   = exp_q;
    cmp_addr_d  = addr_q;
    err_d       = clr ? '0 : (mis && err_q != '1) ? err_q + ERR_CNT_W'(1) : err_q;
    fail_addr_d = clr ? '0 : first ? cmp_addr_q : fail_addr_q;
    fail_data_d = clr ? '0 : first ? data_out : fail_data_q;
    pass_d      = clr ? 1'b0 : done_d ? (err_d == '0) : pass_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wb_q        <= 1'b0;
      exp_q       <= 1'b0;
      cmp_v_q     <= 1'b0;
      cmp_exp_q   <= 1'b0;
      cmp_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
    end else begin
      state_q     <= state_d;
      wb_q        <= wb_d;
      exp_q       <= exp_d;
      cmp_v_q     <= cmp_v_d;
      cmp_exp_q   <= cmp_exp_d;
      cmp_addr_q  <= cmp_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_cnt   = err_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign write_en  = wr_q;
  assign read_en   = rd_q;
  assign addr      = addr_q;
  assign data_in   = din_q;
endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb_ram_bist_ctrl: randomized fault-injection bench for ram_bist_ctrl against a March C- model.
// Honours RAM_BIST_STOP_ON_FAIL_EN the same way as the design.
module tb_ram_bist_ctrl;
  localparam int AW = 5, DW = 8, DEPTH = 1 << AW, N_OPS = 320;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic busy, done, pass, write_en, read_en;
  logic [7:0] err_cnt;
  logic [AW-1:0] fail_addr, addr;
  logic [DW-1:0] fail_data, data_in;
  logic [DW-1:0] data_out = '0;
  logic [DW-1:0] mem [DEPTH];
  logic f_en = 1'b0;
  int f_addr = 0;
  logic [DW-1:0] f_and = '1, f_or = '0;
  logic [AW+DW+1:0] exp_ops[$];
  int exp_err, exp_fa, exp_fd, exp_busy, exp_done;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  ram_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_cnt   (err_cnt),
    .fail_addr (fail_addr),
    .fail_data (fail_data),
    .write_en  (write_en),
    .read_en   (read_en),
    .addr      (addr),
    .data_in   (data_in),
    .data_out  (data_out)
  );

  function automatic logic [DW-1:0] faulty(input int a, input logic [DW-1:0] v);
    return (f_en && a == f_addr) ? ((v & f_and) | f_or) : v;
  endfunction

  always @(posedge clk) begin
    if (write_en) mem[addr] <= data_in;
    if (read_en) data_out <= faulty(int'(addr), mem[addr]);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  // March C- over an array: expected op per cycle and expected result registers
  task automatic build_model();
    int rdv[6] = '{-1, 0, 1, 0, 1, 0};
    int wrv[6] = '{0, 1, 0, 1, 0, -1};
    int dn[6]  = '{0, 0, 0, 1, 1, 1};
    logic [DW-1:0] m [DEPTH];
    logic [DW-1:0] v, want;
    int a, cyc, fail_cyc;
    cyc = 0;
    fail_cyc = 0;
    exp_ops.delete();
    exp_err = 0;
    exp_fa = 0;
    exp_fd = 0;
    for (int e = 0; e < 6; e++)
      for (int i = 0; i < DEPTH; i++) begin
        a = dn[e] != 0 ? DEPTH - 1 - i : i;
        if (rdv[e] >= 0) begin
          v = faulty(a, m[a]);
          want = rdv[e] != 0 ? '1 : '0;
          exp_ops.push_back({2'b01, AW'(a), DW'(0)});
          cyc++;
          if (v != want) begin
            if (exp_err == 0) begin
              exp_fa = a;
              exp_fd = int'(v);
              fail_cyc = cyc;
            end
            if (exp_err < 255) exp_err++;
          end
        end
        if (wrv[e] >= 0) begin
          m[a] = wrv[e] != 0 ? '1 : '0;
          exp_ops.push_back({2'b10, AW'(a), m[a]});
          cyc++;
        end
      end
    exp_busy = N_OPS + 1;
    exp_done = N_OPS + 2;
`ifdef RAM_BIST_STOP_ON_FAIL_EN
    if (exp_err > 0) begin
      exp_err = 1;
      exp_busy = fail_cyc + 1;
      exp_done = fail_cyc + 2;
      while (exp_ops.size() > fail_cyc + 1) void'(exp_ops.pop_back());
    end
`endif
  endtask

  task automatic run(input string tag, input int restart_at);
    int done_at, done_n, busy_n, op_bad;
    logic [AW+DW+1:0] act, want;
    done_at = -1;
    done_n = 0;
    busy_n = 0;
    op_bad = 0;
    build_model();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 400 && (done_at < 0 || c <= done_at + 3); c++) begin
      act = {write_en, read_en, addr, data_in};
      want = (c <= exp_ops.size()) ? exp_ops[c-1] : '0;
      if (act != want) begin
        if (op_bad == 0) $display("  %s first bad op at cycle %0d: %0h vs %0h", tag, c, act, want);
        op_bad++;
      end
      busy_n += int'(busy);
      if (done) begin
        done_n++;
        if (done_at < 0) done_at = c;
      end
      start = (c == restart_at);
      @(negedge clk);
    end
    chk({tag, ".done_at"}, done_at, exp_done);
    chk({tag, ".done_n"}, done_n, 1);
    chk({tag, ".busy_n"}, busy_n, exp_busy);
    chk({tag, ".ops"}, op_bad, 0);
    chk({tag, ".pass"}, pass, exp_err == 0);
    chk({tag, ".err_cnt"}, err_cnt, exp_err);
    chk({tag, ".fail_addr"}, fail_addr, exp_fa);
    chk({tag, ".fail_data"}, fail_data, exp_fd);
  endtask

  task automatic reset_midrun();
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    chk("rst.busy_before", busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("rst.async_outs", {busy, done, pass, err_cnt, fail_addr, fail_data, write_en, read_en, addr, data_in}, '0);
    repeat (3) begin
      @(negedge clk);
      seen |= done;
    end
    rst = 1'b1;
    repeat (8) begin
      @(negedge clk);
      seen |= done | busy;
    end
    chk("rst.no_done", seen, 1'b0);
  endtask

  initial begin
    #12;
    chk("reset.outs", {busy, done, pass, err_cnt, fail_addr, fail_data, write_en, read_en, addr, data_in}, '0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle.outs", {busy, done, pass, err_cnt, write_en, read_en, addr, data_in}, '0);
    run("clean", 0);
    f_en = 1'b1;
    f_addr = 5;
    f_and = 8'hF7;
    f_or = 8'h00;
    run("a5_bit3_sa0", 0);
    f_addr = 31;
    f_and = 8'h00;
    f_or = 8'hA5;
    run("a31_stuck_a5", 0);
    f_en = 1'b0;
    run("restart_ignored", 50);
    reset_midrun();
    run("after_reset", 0);
    repeat (8) begin
      f_en = $urandom_range(0, 3) != 0;
      f_addr = $urandom_range(0, DEPTH - 1);
      f_and = 8'($urandom);
      f_or = 8'($urandom);
      run("random", 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
